// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq
// Sequential NxN matrix multiplier, C = A x B, built around one multiply-accumulate
// unit. A and B stream in row-major, one element pair per beat, then every C element
// is produced in N cycles and streamed out row-major.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid / in_ready  input handshake for one (in_a, in_b) element pair
//   in_a, in_b           A and B elements in row-major order
//   out_valid/out_ready  output handshake for one C element
//   out_data             C element (ACC_W bits, wraps modulo 2^ACC_W)
//   out_row, out_col     position of out_data in C
//   out_last             marks C[N-1][N-1]
//   busy                 high while computing or emitting results
module matrix_mult_seq #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter int SIGNED = 0,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);
  localparam int               PROD_W = 2 * DATA_W;

  state_t state, state_next;

  logic [DATA_W-1:0] a_mem [N][N];
  logic [DATA_W-1:0] b_mem [N][N];

  logic [IDX_W-1:0] ld_row, ld_col;
  logic [IDX_W-1:0] row, col, mac;
  logic [ACC_W-1:0] acc, acc_next, prod_ext;
  logic [PROD_W-1:0] op_a_ext, op_b_ext, prod;

  logic load_fire, load_done, mac_done, out_fire, at_last;

  assign load_fire = in_valid && (state == LOAD);
  assign load_done = load_fire && (ld_row == LAST) && (ld_col == LAST);
  assign mac_done  = (state == COMPUTE) && (mac == LAST);
  assign out_fire  = (state == OUTPUT) && out_ready;
  assign at_last   = (row == LAST) && (col == LAST);

  // Operands are widened to the full product width first, so the low PROD_W bits of
  // the multiply are the exact product for both signed and unsigned operands.
  assign op_a_ext = {{DATA_W{(SIGNED != 0) && a_mem[row][mac][DATA_W-1]}}, a_mem[row][mac]};
  assign op_b_ext = {{DATA_W{(SIGNED != 0) && b_mem[mac][col][DATA_W-1]}}, b_mem[mac][col]};
  assign prod     = op_a_ext * op_b_ext;

  // The product is extended to the accumulator width; when both are equal there is
  // nothing to extend and a zero-width replication must be avoided.
  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign prod_ext = {{(ACC_W - PROD_W){(SIGNED != 0) && prod[PROD_W-1]}}, prod};
    end else begin : g_noext
      assign prod_ext = prod;
    end
  endgenerate

  // First MAC cycle of each element restarts the sum instead of adding to it.
  assign acc_next = ((mac == '0) ? '0 : acc) + prod_ext;

  // Operand storage has no reset; it is only read after a complete load.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      a_mem[ld_row][ld_col] <= in_a;
      b_mem[ld_row][ld_col] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Counters, accumulator and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_row   <= '0;
      ld_col   <= '0;
      row      <= '0;
      col      <= '0;
      mac      <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_fire) begin
            if (ld_col == LAST) begin
              ld_col <= '0;
              ld_row <= (ld_row == LAST) ? '0 : ld_row + 1'b1;
            end else begin
              ld_col <= ld_col + 1'b1;
            end
            if (load_done) begin
              row <= '0;
              col <= '0;
              mac <= '0;
            end
          end
        end
        COMPUTE: begin
          acc <= acc_next;
          if (mac_done) begin
            mac      <= '0;
            out_data <= acc_next;
          end else begin
            mac <= mac + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (at_last) begin
              row    <= '0;
              col    <= '0;
              ld_row <= '0;
              ld_col <= '0;
            end else if (col == LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (load_done) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (mac_done) state_next = OUTPUT;
      end
      OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_fire) state_next = at_last ? LOAD : COMPUTE;
      end
      default: state_next = LOAD;
    endcase
  end

  assign out_row = row;
  assign out_col = col;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq
// Directed bench for matrix_mult_seq. Three instances share clock, reset and input
// data: 3x3 unsigned (sel 0), 3x3 signed (sel 1) and 2x2 with a 16-bit accumulator
// (sel 2). Each instance has its own in_valid; the selected one is observed.
module tb_matrix_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] in_valid;
  logic [7:0] in_a, in_b;
  logic       out_ready;

  logic        u0_in_ready, u0_out_valid, u0_out_last, u0_busy;
  logic [18:0] u0_out_data;
  logic [1:0]  u0_out_row, u0_out_col;
  logic        u1_in_ready, u1_out_valid, u1_out_last, u1_busy;
  logic [18:0] u1_out_data;
  logic [1:0]  u1_out_row, u1_out_col;
  logic        u2_in_ready, u2_out_valid, u2_out_last, u2_busy;
  logic [15:0] u2_out_data;
  logic [0:0]  u2_out_row, u2_out_col;

  matrix_mult_seq #(.N(3), .DATA_W(8), .ACC_W(19), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(u0_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(u0_out_valid), .out_ready(out_ready),
    .out_data(u0_out_data), .out_row(u0_out_row), .out_col(u0_out_col),
    .out_last(u0_out_last), .busy(u0_busy)
  );

  matrix_mult_seq #(.N(3), .DATA_W(8), .ACC_W(19), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(u1_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(u1_out_valid), .out_ready(out_ready),
    .out_data(u1_out_data), .out_row(u1_out_row), .out_col(u1_out_col),
    .out_last(u1_out_last), .busy(u1_busy)
  );

  matrix_mult_seq #(.N(2), .DATA_W(8), .ACC_W(16), .SIGNED(0)) u_dut_2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(u2_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(u2_out_valid), .out_ready(out_ready),
    .out_data(u2_out_data), .out_row(u2_out_row), .out_col(u2_out_col),
    .out_last(u2_out_last), .busy(u2_busy)
  );

  int sel;
  logic        obs_ready, obs_valid, obs_last, obs_busy;
  logic [18:0] obs_data;
  logic [1:0]  obs_row, obs_col;

  // Route the selected instance onto one set of observation signals.
  always_comb begin
    obs_ready = u0_in_ready;
    obs_valid = u0_out_valid;
    obs_last  = u0_out_last;
    obs_busy  = u0_busy;
    obs_data  = u0_out_data;
    obs_row   = u0_out_row;
    obs_col   = u0_out_col;
    case (sel)
      1: begin
        obs_ready = u1_in_ready;
        obs_valid = u1_out_valid;
        obs_last  = u1_out_last;
        obs_busy  = u1_busy;
        obs_data  = u1_out_data;
        obs_row   = u1_out_row;
        obs_col   = u1_out_col;
      end
      2: begin
        obs_ready = u2_in_ready;
        obs_valid = u2_out_valid;
        obs_last  = u2_out_last;
        obs_busy  = u2_busy;
        obs_data  = 19'(u2_out_data);
        obs_row   = 2'(u2_out_row);
        obs_col   = 2'(u2_out_col);
      end
      default: begin
      end
    endcase
  end

  typedef struct {
    string             name;
    int                sel;
    logic [8:0][18:0]  a;
    logic [8:0][18:0]  b;
    logic [8:0][18:0]  c;
    bit                rnd;
    int                gaps;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0][18:0] m9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [8:0][18:0] r;
    r[0] = 19'(e0); r[1] = 19'(e1); r[2] = 19'(e2);
    r[3] = 19'(e3); r[4] = 19'(e4); r[5] = 19'(e5);
    r[6] = 19'(e6); r[7] = 19'(e7); r[8] = 19'(e8);
    return r;
  endfunction

  function automatic vec_t mk(input string name, input int s, input logic [8:0][18:0] a, b, c,
                              input bit rnd, input int gaps);
    vec_t v;
    v.name = name; v.sel = s; v.a = a; v.b = b; v.c = c; v.rnd = rnd; v.gaps = gaps;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive `beats` element pairs into the selected instance with `gaps` idle cycles
  // before each one; returns 1 time unit after the last transferring edge.
  task automatic applyStimulus(input int s, input logic [8:0][18:0] a, b,
                               input int gaps, input int beats);
    sel = s;
    for (int k = 0; k < beats; k++) begin
      repeat (gaps) begin
        @(posedge clk);
        #1;
      end
      in_valid[s] = 1'b1;
      in_a = a[k][7:0];
      in_b = b[k][7:0];
      #0;
      check("in_ready_load", obs_ready, 1);
      @(posedge clk);
      #1;
      in_valid = '0;
    end
  endtask

  // Collect every element of the product and compare against the table.
  task automatic checkOutput(input vec_t v);
    int n;
    n = (v.sel == 2) ? 2 : 3;
    sel = v.sel;
    if (v.rnd) begin
      in_valid[v.sel] = 1'b1;
      in_a = 8'hAA;
      in_b = 8'h55;
    end
    for (int e = 0; e < n * n; e++) begin
      int cyc;
      int stall;
      bit done;
      cyc = 0;
      stall = 0;
      done = 1'b0;
      if (v.rnd) out_ready = 1'b0;
      while (!obs_valid && cyc < 50) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check("out_valid", obs_valid, 1);
      if (!v.rnd) check("latency", cyc, n);
      while (!done) begin
        if (v.rnd) out_ready = (stall >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        #0;
        check("out_data", obs_data, v.c[e]);
        check("out_row", obs_row, e / n);
        check("out_col", obs_col, e % n);
        check("out_last", obs_last, (e == n * n - 1) ? 1 : 0);
        if (v.rnd) check("in_ready_busy", obs_ready, 0);
        done = out_ready;
        stall++;
        @(posedge clk);
        #1;
      end
    end
    in_valid  = '0;
    out_ready = 1'b1;
    #0;
    check("valid_after_last", obs_valid, 0);
    check("busy_after_last", obs_busy, 0);
    check("ready_after_last", obs_ready, 1);
  endtask

  initial begin
    int wait_cyc;
    rst       = 1'b1;
    in_valid  = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    sel       = 0;

    vecs[0] = mk("gapped_reload", 0, m9(1, 2, 3, 4, 5, 6, 7, 8, 9), m9(9, 8, 7, 6, 5, 4, 3, 2, 1),
                 m9(30, 24, 18, 84, 69, 54, 138, 114, 90), 1'b0, 2);
    vecs[1] = mk("identity", 0, m9(1, 2, 3, 4, 5, 6, 7, 8, 9), m9(1, 0, 0, 0, 1, 0, 0, 0, 1),
                 m9(1, 2, 3, 4, 5, 6, 7, 8, 9), 1'b0, 0);
    vecs[2] = mk("all_255", 0, m9(255, 255, 255, 255, 255, 255, 255, 255, 255),
                 m9(255, 255, 255, 255, 255, 255, 255, 255, 255),
                 m9(195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075), 1'b0, 0);
    vecs[3] = mk("backpressure", 0, m9(1, 2, 3, 4, 5, 6, 7, 8, 9), m9(9, 8, 7, 6, 5, 4, 3, 2, 1),
                 m9(30, 24, 18, 84, 69, 54, 138, 114, 90), 1'b1, 0);
    vecs[4] = mk("signed_m128", 1, m9(128, 128, 128, 128, 128, 128, 128, 128, 128),
                 m9(128, 128, 128, 128, 128, 128, 128, 128, 128),
                 m9(49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152, 49152), 1'b0, 0);
    // A = {-1,2,-3; 1,0,0; 0,1,0}, B = {4,0,0; -5,1,0; 6,0,1}
    // C = {-32,2,-3; 4,0,0; -5,1,0}; negatives as 19-bit two's complement
    vecs[5] = mk("signed_mixed", 1, m9(255, 2, 253, 1, 0, 0, 0, 1, 0), m9(4, 0, 0, 251, 1, 0, 6, 0, 1),
                 m9(524256, 2, 524285, 4, 0, 0, 524283, 1, 0), 1'b0, 0);
    vecs[6] = mk("overflow_n2", 2, m9(255, 255, 255, 255, 0, 0, 0, 0, 0),
                 m9(255, 255, 255, 255, 0, 0, 0, 0, 0), m9(64514, 64514, 64514, 64514, 0, 0, 0, 0, 0),
                 1'b0, 0);

    #1;
    check("rst_in_ready", obs_ready, 1);
    check("rst_out_valid", obs_valid, 0);
    check("rst_out_data", obs_data, 0);
    check("rst_out_row", obs_row, 0);
    check("rst_out_col", obs_col, 0);
    check("rst_out_last", obs_last, 0);
    check("rst_busy", obs_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Partial load with gaps, then abort by reset after the fourth beat.
    applyStimulus(0, vecs[0].a, vecs[0].b, 2, 4);
    check("partial_busy", obs_busy, 0);
    rst = 1'b1;
    #1;
    check("abort_in_ready", obs_ready, 1);
    check("abort_busy", obs_busy, 0);
    check("abort_out_valid", obs_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d: %s", i, vecs[i].name);
      applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].gaps, (vecs[i].sel == 2) ? 4 : 9);
      checkOutput(vecs[i]);
    end

    // Asynchronous reset while a result is held under backpressure.
    applyStimulus(0, vecs[2].a, vecs[2].b, 0, 9);
    out_ready = 1'b0;
    wait_cyc = 0;
    while (!obs_valid && wait_cyc < 50) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    check("held_valid", obs_valid, 1);
    check("held_data", obs_data, 195075);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", obs_valid, 0);
    check("async_out_data", obs_data, 0);
    check("async_busy", obs_busy, 0);
    check("async_in_ready", obs_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Recovery after the abort.
    applyStimulus(vecs[1].sel, vecs[1].a, vecs[1].b, 0, 9);
    checkOutput(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
